// File: rtl/pcie_ddr_reset_sequencer.sv
// pcie_ddr_reset_sequencer
// Power-up reset sequencer for the PCIe/AXI/DDR3 subsystem. Releases N_CH
// active-low resets one at a time in channel order. Each released channel must
// report ready before a timeout. After it reports ready, the sequencer waits a
// settle period before releasing the next channel. Once the sequence is
// complete, it keeps watching every ready line. It also drives heartbeat and
// status LEDs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; all channels held in reset, waiting for start
// ST_WAIT  | cur_ch released, waiting for its synchronised ready (timeout)
// ST_HOLD  | cur_ch ready, settling before releasing the next channel
// ST_DONE  | every channel released and ready; ready lines monitored
// ST_ERROR | timeout or ready drop; all channels back in reset until start
module pcie_ddr_reset_sequencer #(
    parameter int N_CH           = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HB_BITS        = 24,
    parameter int LED_W          = 8,
    localparam int CHW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  ch_ready,
    output logic [N_CH-1:0]  ch_rst_n,
    output logic             seq_done,
    output logic             seq_error,
    output logic [CHW-1:0]   err_ch,
    output logic [CHW-1:0]   cur_ch,
    output logic [LED_W-1:0] led_o
);

    // One counter serves both the ready timeout and the settle period, so it
    // must be wide enough for whichever of the two is longer.
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int CNT_W  = (TO_W > HOLD_W) ? TO_W : HOLD_W;

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CHW-1:0]   LAST_CH   = CHW'(N_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CHW-1:0]     cur_ch_q, cur_ch_d;
    logic [N_CH-1:0]    ch_rst_n_q, ch_rst_n_d;
    logic               seq_done_q, seq_done_d;
    logic               seq_error_q, seq_error_d;
    logic [CHW-1:0]     err_ch_q, err_ch_d;
    logic [HB_BITS-1:0] hb_q, hb_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [N_CH-1:0]    rdy_m_q, rdy_m_d;
    logic [N_CH-1:0]    rdy_s_q, rdy_s_d;

    logic               rdy_cur;
    logic               drop_hit;
    logic [CHW-1:0]     drop_ch;
    logic               hold_end;
    logic               timeout_hit;
    logic [CHW-1:0]     nxt_ch;
    logic [LED_W-4:0]   led_ch;

    assign hold_end    = (cnt_q == HOLD_LAST);
    assign timeout_hit = (cnt_q == TO_LAST);
    assign nxt_ch      = cur_ch_q + CHW'(1);

    // Two-stage synchroniser for the asynchronous ready inputs
    always_comb begin
        rdy_m_d = ch_ready;
        rdy_s_d = rdy_m_q;
    end

    // Ready of the channel being sequenced, plus the lowest channel whose ready dropped
    always_comb begin
        rdy_cur  = 1'b0;
        drop_hit = 1'b0;
        drop_ch  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (CHW'(k) == cur_ch_q) begin
                rdy_cur = rdy_s_q[k];
            end
            if (!rdy_s_q[k] &&
                ((state_q == ST_WAIT && CHW'(k) < cur_ch_q) ||
                 ((state_q == ST_HOLD || state_q == ST_DONE) && CHW'(k) <= cur_ch_q))) begin
                drop_hit = 1'b1;
                drop_ch  = CHW'(k);
            end
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready drop outranks both the timeout and the settle end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (drop_hit)         state_d = ST_ERROR;
                else if (rdy_cur)     state_d = ST_HOLD;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_HOLD: begin
                if (drop_hit)      state_d = ST_ERROR;
                else if (hold_end) state_d = (cur_ch_q == LAST_CH) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                if (drop_hit) state_d = ST_ERROR;
            end
            ST_ERROR: begin
                if (start) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter, channel pointer, reset releases and status flags for the next cycle
    always_comb begin
        cnt_d       = cnt_q;
        cur_ch_d    = cur_ch_q;
        ch_rst_n_d  = ch_rst_n_q;
        seq_done_d  = seq_done_q;
        seq_error_d = seq_error_q;
        err_ch_d    = err_ch_q;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    cnt_d       = '0;
                    cur_ch_d    = '0;
                    ch_rst_n_d  = N_CH'(1);
                    seq_done_d  = 1'b0;
                    seq_error_d = 1'b0;
                    err_ch_d    = '0;
                end
            end
            ST_WAIT: begin
                if (!drop_hit) begin
                    if (rdy_cur) cnt_d = '0;
                    else         cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!drop_hit) begin
                    if (hold_end) begin
                        cnt_d = '0;
                        if (cur_ch_q == LAST_CH) begin
                            seq_done_d = 1'b1;
                        end else begin
                            cur_ch_d   = nxt_ch;
                            ch_rst_n_d = ch_rst_n_q | (N_CH'(1) << nxt_ch);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Any entry into ERROR pulls every channel back into reset at once
        if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            cnt_d       = '0;
            ch_rst_n_d  = '0;
            seq_done_d  = 1'b0;
            seq_error_d = 1'b1;
            err_ch_d    = drop_hit ? drop_ch : cur_ch_q;
        end
    end

    // Channel reset bits shown on the LEDs: zero-padded or truncated to the LED field
    for (genvar i = 0; i < LED_W - 3; i++) begin : g_led
        if (i < N_CH) begin : g_ch
            assign led_ch[i] = ch_rst_n_d[i];
        end else begin : g_pad
            assign led_ch[i] = 1'b0;
        end
    end

    // Heartbeat and LED image; LEDs track the same-cycle status outputs
    always_comb begin
        hb_d             = hb_q + 1'b1;
        led_d            = '0;
        led_d[0]         = hb_d[HB_BITS-1];
        led_d[1]         = seq_done_d;
        led_d[2]         = seq_error_d;
        led_d[LED_W-1:3] = led_ch;
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            cur_ch_q    <= '0;
            ch_rst_n_q  <= '0;
            seq_done_q  <= 1'b0;
            seq_error_q <= 1'b0;
            err_ch_q    <= '0;
            hb_q        <= '0;
            led_q       <= '0;
            rdy_m_q     <= '0;
            rdy_s_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cur_ch_q    <= cur_ch_d;
            ch_rst_n_q  <= ch_rst_n_d;
            seq_done_q  <= seq_done_d;
            seq_error_q <= seq_error_d;
            err_ch_q    <= err_ch_d;
            hb_q        <= hb_d;
            led_q       <= led_d;
            rdy_m_q     <= rdy_m_d;
            rdy_s_q     <= rdy_s_d;
        end
    end

    assign ch_rst_n  = ch_rst_n_q;
    assign seq_done  = seq_done_q;
    assign seq_error = seq_error_q;
    assign err_ch    = err_ch_q;
    assign cur_ch    = cur_ch_q;
    assign led_o     = led_q;

endmodule

// File: tb/tb_pcie_ddr_reset_sequencer.sv
// Bench for pcie_ddr_reset_sequencer (N_CH=4, HOLD=4, TIMEOUT=32, HB=4, LED=8).
// An event/timestamp reference model predicts every output each cycle; directed
// scenarios add literal timing expectations, then a randomised phase follows.
module tb_pcie_ddr_reset_sequencer;

    localparam int N_CH    = 4;
    localparam int HOLD    = 4;
    localparam int TO      = 32;
    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_HOLD  = 2;
    localparam int P_DONE  = 3;
    localparam int P_ERR   = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic [3:0] ch_ready  = 4'b0000;
    logic [3:0] ch_rst_n;
    logic       seq_done;
    logic       seq_error;
    logic [1:0] err_ch;
    logic [1:0] cur_ch;
    logic [7:0] led_o;

    int checks = 0;
    int errors = 0;
    int tick   = 0;
    int rise_t [4];

    pcie_ddr_reset_sequencer #(
        .N_CH(4), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(32), .HB_BITS(4), .LED_W(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .ch_ready(ch_ready),
        .ch_rst_n(ch_rst_n), .seq_done(seq_done), .seq_error(seq_error),
        .err_ch(err_ch), .cur_ch(cur_ch), .led_o(led_o)
    );

    always #5 sys_clk = ~sys_clk;

    always begin
        @(posedge sys_clk);
        tick++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_phase = P_IDLE;
    int         m_cur   = 0;
    int         m_t0    = 0;
    int         m_cyc   = 0;
    int         m_errch = 0;
    logic [3:0] m_rel   = 4'b0000;
    logic       m_done  = 1'b0;
    logic       m_err   = 1'b0;
    logic [3:0] h1      = 4'b0000;
    logic [3:0] h2      = 4'b0000;

    function automatic int lowest_drop(input logic [3:0] r, input int upto);
        for (int k = 0; k <= upto; k++) if (!r[k]) return k;
        return -1;
    endfunction

    task automatic m_fail(input int k);
        m_phase = P_ERR;
        m_rel   = 4'b0000;
        m_done  = 1'b0;
        m_err   = 1'b1;
        m_errch = k;
    endtask

    always begin
        logic [3:0] seen;
        int         low;
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            m_phase = P_IDLE; m_cur = 0; m_t0 = 0; m_cyc = 0; m_errch = 0;
            m_rel = 4'b0000; m_done = 1'b0; m_err = 1'b0; h1 = 4'b0000; h2 = 4'b0000;
        end else begin
            // decisions see the ready lines as they were two edges ago
            seen = h2;
            h2   = h1;
            h1   = ch_ready;
            m_cyc++;
            case (m_phase)
                P_IDLE, P_ERR: begin
                    if (start) begin
                        m_phase = P_WAIT; m_cur = 0; m_rel = 4'b0001;
                        m_done = 1'b0; m_err = 1'b0; m_errch = 0; m_t0 = m_cyc;
                    end
                end
                P_WAIT: begin
                    low = lowest_drop(seen, m_cur - 1);
                    if (low >= 0) m_fail(low);
                    else if (seen[m_cur]) begin m_phase = P_HOLD; m_t0 = m_cyc; end
                    else if (m_cyc - m_t0 == TO) m_fail(m_cur);
                end
                P_HOLD: begin
                    low = lowest_drop(seen, m_cur);
                    if (low >= 0) m_fail(low);
                    else if (m_cyc - m_t0 == HOLD) begin
                        if (m_cur == N_CH - 1) begin
                            m_phase = P_DONE; m_done = 1'b1;
                        end else begin
                            m_cur++;
                            m_rel[m_cur] = 1'b1;
                            m_phase = P_WAIT;
                            m_t0 = m_cyc;
                        end
                    end
                end
                P_DONE: begin
                    low = lowest_drop(seen, N_CH - 1);
                    if (low >= 0) m_fail(low);
                end
                default: ;
            endcase
        end
    end

    // per-cycle compare against the model
    always begin
        logic [7:0] exp_led;
        @(negedge sys_clk);
        exp_led = {1'b0, m_rel, m_err, m_done, ((m_cyc % 16) >= 8) ? 1'b1 : 1'b0};
        chk("cmp_ch_rst_n",  ch_rst_n,  m_rel);
        chk("cmp_seq_done",  seq_done,  m_done);
        chk("cmp_seq_error", seq_error, m_err);
        chk("cmp_err_ch",    err_ch,    m_errch);
        chk("cmp_cur_ch",    cur_ch,    m_cur);
        chk("cmp_led_o",     led_o,     exp_led);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_rst_bit(input int k, input int budget);
        int n = 0;
        while (ch_rst_n[k] !== 1'b1 && n < budget) begin step(1); n++; end
        chk($sformatf("wait_ch_rst_n%0d", k), ch_rst_n[k], 1'b1);
    endtask

    task automatic wait_out(input int which, input int budget);
        int n = 0;
        while (((which == 0) ? seq_done : seq_error) !== 1'b1 && n < budget) begin step(1); n++; end
        chk((which == 0) ? "wait_seq_done" : "wait_seq_error",
            (which == 0) ? seq_done : seq_error, 1'b1);
    endtask

    // release each channel's ready dly cycles after its reset rises
    task automatic run_chans(input int n, input int dly);
        for (int k = 0; k < n; k++) begin
            wait_rst_bit(k, 60);
            rise_t[k] = tick;
            step(dly - 1);
            ch_ready[k] = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ch_rst_n"},  ch_rst_n,  0);
        chk({tag, "_seq_done"},  seq_done,  0);
        chk({tag, "_seq_error"}, seq_error, 0);
        chk({tag, "_err_ch"},    err_ch,    0);
        chk({tag, "_cur_ch"},    cur_ch,    0);
        chk({tag, "_led_o"},     led_o,     0);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;

        // 1: asynchronous reset with the heartbeat LED lit, then heartbeat period
        repeat (10) @(posedge sys_clk);
        chk("hb_before_rst", led_o[0], 1'b1);
        #3 sys_rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #2 sys_rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (i == 7)  chk("hb_cycle7",  led_o[0], 1'b0);
            if (i == 8)  chk("hb_cycle8",  led_o[0], 1'b1);
            if (i == 16) chk("hb_cycle16", led_o[0], 1'b0);
        end
        chk("idle_ch_rst_n", ch_rst_n, 4'b0000);

        // 2: normal sequence, ready 5 cycles after each release
        pulse_start();
        chk("first_release", ch_rst_n, 4'b0001);
        run_chans(4, 5);
        wait_out(0, 40);
        for (int k = 1; k < 4; k++)
            chk($sformatf("step_gap%0d", k), rise_t[k] - rise_t[k-1], 11);
        chk("done_ch_rst_n", ch_rst_n, 4'b1111);
        chk("done_led1", led_o[1], 1'b1);
        chk("done_led_ch", led_o[7:3], 5'b01111);

        // 4: one-cycle drop of ready[1] while DONE
        step(3);
        t = tick;
        ch_ready[1] = 1'b0;
        step(1);
        ch_ready[1] = 1'b1;
        wait_out(1, 10);
        chk("drop_latency", tick - t, 3);
        chk("drop_err_ch", err_ch, 2'd1);
        chk("drop_seq_done", seq_done, 1'b0);
        chk("drop_ch_rst_n", ch_rst_n, 4'b0000);

        // 5: restart from ERROR, start ignored while busy; 3: timeout on channel 2
        ch_ready = 4'b0000;
        step(3);
        pulse_start();
        chk("restart_seq_error", seq_error, 1'b0);
        chk("restart_ch_rst_n", ch_rst_n, 4'b0001);
        pulse_start();
        chk("busy_ch_rst_n", ch_rst_n, 4'b0001);
        chk("busy_cur_ch", cur_ch, 2'd0);
        run_chans(2, 5);
        wait_rst_bit(2, 60);
        t = tick;
        wait_out(1, 60);
        chk("timeout_latency", tick - t, 32);
        chk("timeout_err_ch", err_ch, 2'd2);
        chk("timeout_ch_rst_n", ch_rst_n, 4'b0000);

        ch_ready = 4'b0000;
        step(3);
        pulse_start();
        run_chans(4, 5);
        wait_out(0, 40);
        chk("rerun_ch_rst_n", ch_rst_n, 4'b1111);

        // 6: reset during HOLD of channel 1
        ch_ready = 4'b0000;
        step(4);
        pulse_start();
        run_chans(2, 5);
        step(4);
        chk("hold_cur_ch", cur_ch, 2'd1);
        #2 sys_rst_n = 1'b0;
        #1 chk_all_zero("midop_rst");
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        step(10);
        chk("post_rst_ch_rst_n", ch_rst_n, 4'b0000);
        chk("post_rst_seq_done", seq_done, 1'b0);

        // randomised episodes checked by the model
        for (int ep = 0; ep < 40; ep++) begin
            int dl [4];
            int g;
            ch_ready = 4'b0000;
            start    = 1'b0;
            step(40);
            for (int k = 0; k < 4; k++) dl[k] = int'($urandom_range(1, 40));
            start = 1'b1;
            for (int c = 0; c < 200; c++) begin
                step(1);
                start = ($urandom_range(0, 7) == 0);
                for (int k = 0; k < 4; k++) begin
                    if (ch_rst_n[k]) begin
                        if (dl[k] > 1) dl[k]--;
                        else ch_ready[k] = 1'b1;
                    end else begin
                        ch_ready[k] = ($urandom_range(0, 19) == 0);
                    end
                end
                if ($urandom_range(0, 149) == 0) begin
                    g = int'($urandom_range(0, 3));
                    ch_ready[g] = 1'b0;
                end
                if ($urandom_range(0, 399) == 0) begin
                    #2 sys_rst_n = 1'b0;
                    #4 sys_rst_n = 1'b1;
                end
            end
            start = 1'b0;
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
